spike_bank_buffer: RTL



---
 rtl/spike_bank_buffer_pkg.sv | 22 ++
 rtl/spike_bank_buffer_bram.sv | 24 ++
 rtl/spike_bank_buffer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spike_bank_buffer_pkg.sv
// Shared definitions for the spike bank buffer: marker defaults, the legacy
// conv1 sizing constants and the writer state encoding.
package spike_bank_buffer_pkg;

   localparam int CONV1_ADDR    = 9;
   localparam int SYNAPSE_INDEX = 16;

   localparam logic [15:0] SOF_WORD_DEF = 16'hF1FA;
   localparam logic [15:0] EOF_WORD_DEF = 16'hFAF1;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FILL = 2'd1,
      W_WAIT = 2'd2
   } wr_state_e;

   // Bank pointer width; a single bank still needs a 1-bit pointer.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spike_bank_buffer_bram.sv
// Simple dual-port RAM for one bank: synchronous write, asynchronous read.
// The read port is registered once in the top after the bank mux.
module spike_bank_buffer_bram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Write port.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spike_bank_buffer.sv
// N-bank ping-pong buffer: frames SOF/EOF-delimited spike indices from a
// show-ahead FIFO into free banks; the consumer reads the oldest committed
// bank and hands it back with a release pulse.
// Optional feature macro: SPIKE_BUF_OVF_EN (saturate and flag overflow).
//
// state  | meaning
// W_IDLE | bank w_ptr free, dropping words until SOF
// W_FILL | writing data words of a frame into bank w_ptr
// W_WAIT | bank w_ptr still held by the consumer, FIFO not popped
module spike_bank_buffer
   import spike_bank_buffer_pkg::*;
#(
   parameter int               NUM_BANKS = 2,
   parameter int               ADDR_W    = CONV1_ADDR,
   parameter int               DATA_W    = SYNAPSE_INDEX,
   parameter logic [DATA_W-1:0] SOF_WORD = DATA_W'(SOF_WORD_DEF),
   parameter logic [DATA_W-1:0] EOF_WORD = DATA_W'(EOF_WORD_DEF)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_W-1:0]                s_index_i,
   input  logic                             empty,
   output logic                             r_en,
   input  logic [ADDR_W-1:0]                rd_addr,
   output logic [DATA_W-1:0]                rd_data,
   output logic                             rd_valid,
   output logic [ADDR_W:0]                  rd_count,
   output logic [ptr_width(NUM_BANKS)-1:0]  rd_bank,
   // "release" is a reserved word, hence the suffix.
   input  logic                             release_i,
   output logic                             ovf
);

   localparam int PTR_W = ptr_width(NUM_BANKS);
   localparam int DEPTH = 2**ADDR_W;

   wr_state_e          state_q;
   logic [ADDR_W:0]    wr_addr_q;
   logic [PTR_W-1:0]   w_ptr_q, r_ptr_q, w_ptr_nxt;
   logic [NUM_BANKS-1:0] full_q, full_d;
   logic [ADDR_W:0]    count_q [NUM_BANKS];
   logic [DATA_W-1:0]  bank_rdata [NUM_BANKS];
   logic [DATA_W-1:0]  rd_data_q;
   logic               is_sof, is_eof, commit, rel_fire, ovf_hit, wr_en;

   function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
   endfunction

   // No pops while reset is held, so reset never eats FIFO words.
   assign r_en      = !rst && !empty && (state_q != W_WAIT);
   assign is_sof    = (s_index_i == SOF_WORD);
   assign is_eof    = (s_index_i == EOF_WORD);
   assign commit    = r_en && (state_q == W_FILL) && is_eof;
   assign rel_fire  = release_i && full_q[r_ptr_q];
   assign w_ptr_nxt = inc_ptr(w_ptr_q);

`ifdef SPIKE_BUF_OVF_EN
   assign ovf_hit = (wr_addr_q == (ADDR_W+1)'(DEPTH));
`else
   assign ovf_hit = 1'b0;
`endif

   assign wr_en = r_en && (state_q == W_FILL) && !is_sof && !is_eof && !ovf_hit;

   // Commit sets and release clears; they never hit the same bank together.
   always_comb begin
      full_d = full_q;
      if (commit)   full_d[w_ptr_q] = 1'b1;
      if (rel_fire) full_d[r_ptr_q] = 1'b0;
   end

   // Writer FSM: framing, write address, per-bank count and bank rotation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= W_IDLE;
         wr_addr_q <= '0;
         w_ptr_q   <= '0;
         for (int b = 0; b < NUM_BANKS; b++) count_q[b] <= '0;
      end else begin
         case (state_q)
            W_WAIT: begin
               if (!full_d[w_ptr_q]) state_q <= W_IDLE;
            end
            W_IDLE: begin
               if (r_en && is_sof) begin
                  state_q   <= W_FILL;
                  wr_addr_q <= '0;
               end
            end
            W_FILL: begin
               if (r_en) begin
                  if (is_sof) begin
                     wr_addr_q <= '0;
                  end else if (is_eof) begin
                     count_q[w_ptr_q] <= wr_addr_q;
                     w_ptr_q          <= w_ptr_nxt;
                     state_q          <= full_d[w_ptr_nxt] ? W_WAIT : W_IDLE;
                  end else if (!ovf_hit) begin
                     wr_addr_q <= wr_addr_q + 1'b1;
                  end
               end
            end
            default: state_q <= W_IDLE;
         endcase
      end
   end

   // Reader side: bank occupancy, read pointer and registered read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q    <= '0;
         r_ptr_q   <= '0;
         rd_data_q <= '0;
      end else begin
         full_q    <= full_d;
         rd_data_q <= bank_rdata[r_ptr_q];
         if (rel_fire) r_ptr_q <= inc_ptr(r_ptr_q);
      end
   end

`ifdef SPIKE_BUF_OVF_EN
   logic ovf_q;

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)                                      ovf_q <= 1'b0;
      else if (r_en && (state_q == W_FILL) && !is_sof && !is_eof && ovf_hit) ovf_q <= 1'b1;
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      spike_bank_buffer_bram #(
         .ADDR_W (ADDR_W),
         .DATA_W (DATA_W)
      ) u_bram (
         .clk     (clk),
         .we_i    (wr_en && (w_ptr_q == PTR_W'(b))),
         .waddr_i (wr_addr_q[ADDR_W-1:0]),
         .wdata_i (s_index_i),
         .raddr_i (rd_addr),
         .rdata_o (bank_rdata[b])
      );
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = full_q[r_ptr_q];
   assign rd_count = count_q[r_ptr_q];
   assign rd_bank  = r_ptr_q;

endmodule
